// File: rtl/tt_sweep_if.sv
// rtl/tt_sweep_if.sv - stimulus/response bundle between a sweep checker and its environment
interface tt_sweep_if #(
    parameter int N_IN = 5
);
    logic            start;
    logic            dut_y;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic            fail_seen;
    logic [N_IN-1:0] first_fail;

    // master: environment that requests sweeps and returns the gate output
    modport master (
        output start,
        output dut_y,
        input  vec,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  fail_seen,
        input  first_fail
    );

    // slave: the checker itself
    modport slave (
        input  start,
        input  dut_y,
        output vec,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output fail_seen,
        output first_fail
    );
endinterface

// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - exhaustive truth-table sweep checker for a small gate network
// Optional: define TT_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module tt_sweep_checker #(
    parameter int                N_IN       = 5,
    parameter int                SETTLE_CYC = 2,
    parameter logic [2**N_IN-1:0] TT        = 32'hA8A8A800
) (
    input  logic       clk,
    input  logic       rst,
    tt_sweep_if.slave  bus
);

    localparam int                CW        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0]     CNT_LOAD  = CW'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]   VEC_LAST  = '1;
    localparam logic [N_IN:0]     ERR_MAX   = (N_IN+1)'(2**N_IN);
    localparam logic [N_IN:0]     ERR_ONE   = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [N_IN-1:0] vec_q, vec_n;
    logic            busy_q, busy_n;
    logic            done_q, done_n;
    logic            pass_q, pass_n;
    logic [N_IN:0]   err_q, err_n;
    logic            fail_q, fail_n;
    logic [N_IN-1:0] first_q, first_n;
    logic            mismatch;
    logic            last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= 1'b0;
            first_q <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            vec_q   <= vec_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
            err_q   <= err_n;
            fail_q  <= fail_n;
            first_q <= first_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        vec_n    = vec_q;
        busy_n   = busy_q;
        done_n   = done_q;
        pass_n   = pass_q;
        err_n    = err_q;
        fail_n   = fail_q;
        first_n  = first_q;
        mismatch = 1'b0;
        last     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = SETTLE;
                    cnt_n   = CNT_LOAD;
                    vec_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    err_n   = '0;
                    fail_n  = 1'b0;
                    first_n = '0;
                end
            end

            SETTLE: begin
                if (cnt_q == '0) begin
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end

            SAMPLE: begin
                mismatch = (bus.dut_y != TT[vec_q]);
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_n = err_q + ERR_ONE;
                    end
                    if (!fail_q) begin
                        first_n = vec_q;
                        fail_n  = 1'b1;
                    end
                end
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
                last = (vec_q == VEC_LAST) || mismatch;
`else
                last = (vec_q == VEC_LAST);
`endif
                if (last) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    // err_n already folds in this cycle's mismatch
                    pass_n  = (err_n == '0);
                end else begin
                    state_n = SETTLE;
                    vec_n   = vec_q + 1'b1;
                    cnt_n   = CNT_LOAD;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign bus.vec        = vec_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_q;
    assign bus.fail_seen  = fail_q;
    assign bus.first_fail = first_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb/tb_tt_sweep_checker.sv - self-checking bench for tt_sweep_checker
module tb_tt_sweep_checker;

    localparam int          N_IN   = 5;
    localparam int          SC     = 2;
    localparam logic [31:0] TT_REF = 32'hA8A8A800;
    localparam int          NVEC   = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] resp_tab = TT_REF;

    int checks = 0;
    int errors = 0;

    tt_sweep_if #(.N_IN(N_IN)) bus ();

    tt_sweep_checker #(
        .N_IN      (N_IN),
        .SETTLE_CYC(SC),
        .TT        (TT_REF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Gate network under test is modelled as a response table indexed by vec
    assign bus.dut_y = resp_tab[bus.vec];

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] resp;
        int          exp_err;
        int          exp_first;
        int          repulse;
    } row_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_vec"},        int'(bus.vec), 0);
        chk({tag, "_busy"},       int'(bus.busy), 0);
        chk({tag, "_done"},       int'(bus.done), 0);
        chk({tag, "_pass"},       int'(bus.pass), 0);
        chk({tag, "_err_cnt"},    int'(bus.err_cnt), 0);
        chk({tag, "_fail_seen"},  int'(bus.fail_seen), 0);
        chk({tag, "_first_fail"}, int'(bus.first_fail), 0);
    endtask

    // Reference: mismatch set is resp XOR golden table, scanned in vector order
    task automatic model(input logic [31:0] resp, output int err, output int first);
        logic [31:0] diff;
        diff  = resp ^ TT_REF;
        err   = 0;
        first = 0;
        for (int i = 0; i < NVEC; i++) begin
            if (diff[i]) begin
                if (err == 0) first = i;
                err++;
            end
        end
    endtask

    task automatic run_sweep(input string tag, input logic [31:0] resp,
                             input int exp_err, input int exp_first, input int repulse);
        int n;
        int e_err, e_vec, e_cyc;
        bit busy_gap;
        e_err = exp_err;
        e_vec = NVEC - 1;
        e_cyc = NVEC * (SC + 1);
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        if (exp_err > 0) begin
            e_err = 1;
            e_vec = exp_first;
            e_cyc = (exp_first + 1) * (SC + 1);
        end
`endif
        resp_tab = resp;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({tag, "_acc_busy"},  int'(bus.busy), 1);
        chk({tag, "_acc_done"},  int'(bus.done), 0);
        chk({tag, "_acc_err"},   int'(bus.err_cnt), 0);
        chk({tag, "_acc_fseen"}, int'(bus.fail_seen), 0);
        chk({tag, "_acc_vec"},   int'(bus.vec), 0);
        n = 0;
        busy_gap = 1'b0;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            bus.start = 1'b0;
            if (bus.done) break;
            if (!bus.busy) busy_gap = 1'b1;
            if (n > 4 * NVEC * (SC + 1)) begin
                chk({tag, "_timeout"}, n, e_cyc);
                return;
            end
            if (n == repulse) bus.start = 1'b1;
        end
        chk({tag, "_cycles"},     n, e_cyc);
        chk({tag, "_busy_gap"},   int'(busy_gap), 0);
        chk({tag, "_busy_end"},   int'(bus.busy), 0);
        chk({tag, "_err_cnt"},    int'(bus.err_cnt), e_err);
        chk({tag, "_first_fail"}, int'(bus.first_fail), (exp_err > 0) ? exp_first : 0);
        chk({tag, "_fail_seen"},  int'(bus.fail_seen), (exp_err > 0) ? 1 : 0);
        chk({tag, "_pass"},       int'(bus.pass), (exp_err == 0) ? 1 : 0);
        chk({tag, "_vec_end"},    int'(bus.vec), e_vec);
        // Results must hold in DONE whatever the gate output does
        resp_tab = ~resp;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_hold_done"}, int'(bus.done), 1);
        chk({tag, "_hold_err"},  int'(bus.err_cnt), e_err);
        chk({tag, "_hold_vec"},  int'(bus.vec), e_vec);
    endtask

    row_t rows[6];

    initial begin
        int r_err, r_first, n;
        logic [31:0] rr;

        rows[0] = '{"good",    TT_REF,                   0,  0, 40};
        rows[1] = '{"stuck0",  32'h0000_0000,            9, 11, -1};
        rows[2] = '{"stuck1",  32'hFFFF_FFFF,           23,  0, -1};
        rows[3] = '{"fault0",  TT_REF ^ 32'h0000_0001,   1,  0, -1};
        rows[4] = '{"fault31", TT_REF ^ 32'h8000_0000,   1, 31, -1};
        rows[5] = '{"fault2",  TT_REF ^ 32'h0001_0400,   2, 10, -1};

        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_beats_start", int'(bus.busy), 0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_no_start", int'(bus.busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_sweep(rows[i].name, rows[i].resp, rows[i].exp_err,
                      rows[i].exp_first, rows[i].repulse);
        end

        // Reset in the middle of a sweep, while vec=17 is settling
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        resp_tab = TT_REF ^ 32'h0010_0000;
`else
        resp_tab = 32'h0000_0000;
`endif
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.vec != 5'd17 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_reach_17", int'(bus.vec), 17);
        chk("mid_busy", int'(bus.busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle_zero("mid_reset");
        @(posedge clk);
        #1;
        chk("mid_stays_idle", int'(bus.busy), 0);
        run_sweep("after_reset", TT_REF, 0, 0, -1);

        for (int k = 0; k < 8; k++) begin
            rr = TT_REF;
            if (k != 0) rr = TT_REF ^ ($urandom() & $urandom() & $urandom());
            model(rr, r_err, r_first);
            run_sweep($sformatf("rand%0d", k), rr, r_err, r_first, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
